// File: rtl/sfu_array.sv
// sfu_array -- multi-channel special-function unit below the PE-array columns.
//
// Each of `col` channels keeps a signed saturating accumulator. A readout
// request copies every accumulator (optionally through ReLU) into the
// registered output vector for one out_valid pulse and clears the unit.
// Accumulation always wins over readout; a request that arrives while data
// is still streaming is remembered and executed on the first idle cycle.
//
// Ports:
//   clk        clock, rising-edge active
//   rst        synchronous active-low reset
//   in_valid   accumulate `in` this cycle
//   in         col x psum_bw signed partial sums, channel c at [c*psum_bw +: psum_bw]
//   relu_en    clamp negative results to zero on the readout cycle
//   rd_req     request readout of all channels
//   out_valid  one-cycle pulse marking fresh results on `out`
//   out        registered result vector, same packing as `in`
//   acc_cnt    accumulations since last clear (saturating)
//   sat_flag   per-channel sticky saturation indicator since last clear

module sfu_array #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int cnt_bw  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [col*psum_bw-1:0] in,
   input  logic                   relu_en,
   input  logic                   rd_req,
   output logic                   out_valid,
   output logic [col*psum_bw-1:0] out,
   output logic [cnt_bw-1:0]      acc_cnt,
   output logic [col-1:0]         sat_flag
);

   localparam logic [psum_bw-1:0] ACC_MAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] ACC_MIN = {1'b1, {(psum_bw-1){1'b0}}};
   localparam logic [cnt_bw-1:0]  CNT_ONE = {{(cnt_bw-1){1'b0}}, 1'b1};
   localparam logic [cnt_bw-1:0]  CNT_MAX = {cnt_bw{1'b1}};

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   state_t state;
   state_t state_next;
   logic   do_read;

   logic [psum_bw-1:0] acc      [col];
   logic [psum_bw-1:0] acc_sat  [col];
   logic [psum_bw-1:0] relu_val [col];
   logic [col-1:0]     sat_hit;

   // Per-channel datapath: the sum is formed one bit wider so that overflow
   // shows up as a disagreement between the top two bits; the top bit then
   // tells which rail to clamp to.
   for (genvar c = 0; c < col; c++) begin : g_ch
      logic [psum_bw-1:0] in_ch;
      logic [psum_bw:0]   sum;

      assign in_ch       = in[c*psum_bw +: psum_bw];
      assign sum         = {acc[c][psum_bw-1], acc[c]} + {in_ch[psum_bw-1], in_ch};
      assign sat_hit[c]  = sum[psum_bw] ^ sum[psum_bw-1];
      assign acc_sat[c]  = !sat_hit[c] ? sum[psum_bw-1:0]
                         : (sum[psum_bw] ? ACC_MIN : ACC_MAX);
      assign relu_val[c] = (relu_en && acc[c][psum_bw-1]) ? '0 : acc[c];
   end

   // Readout control: a request seen together with in_valid is parked in
   // PEND; readout fires on any cycle with a live or parked request and no
   // incoming data.
   always_comb begin
      state_next = state;
      do_read    = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req) begin
               if (in_valid) state_next = PEND;
               else          do_read    = 1'b1;
            end
         end
         PEND: begin
            if (!in_valid) begin
               state_next = IDLE;
               do_read    = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, accumulators, counter, flags and the registered output vector.
   // Accumulation and readout are mutually exclusive because readout only
   // fires when in_valid is low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         acc_cnt   <= '0;
         sat_flag  <= '0;
         for (int c = 0; c < col; c++) acc[c] <= '0;
      end else begin
         state     <= state_next;
         out_valid <= do_read;
         if (in_valid) begin
            for (int c = 0; c < col; c++) acc[c] <= acc_sat[c];
            sat_flag <= sat_flag | sat_hit;
            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CNT_ONE;
         end else if (do_read) begin
            for (int c = 0; c < col; c++) begin
               out[c*psum_bw +: psum_bw] <= relu_val[c];
               acc[c]                    <= '0;
            end
            acc_cnt  <= '0;
            sat_flag <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sfu_array.sv
// tb_sfu_array -- scoreboard bench for sfu_array.
//
// The driver issues one cycle of stimulus at a time and advances a
// behavioural model (integer accumulators with explicit clamping) at the
// same clock edge; each readout the model predicts is pushed onto a queue.
// A monitor on the falling edge pops and compares whenever out_valid is
// seen, and otherwise checks that out is holding its last value.

module tb_sfu_array;

   localparam int COL = 8;
   localparam int PBW = 16;
   localparam int CBW = 4;
   localparam int W   = COL * PBW;
   localparam int VMAX = 32767;
   localparam int VMIN = -32768;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic [W-1:0]   in;
   logic           relu_en;
   logic           rd_req;
   logic           out_valid;
   logic [W-1:0]   out;
   logic [CBW-1:0] acc_cnt;
   logic [COL-1:0] sat_flag;

   sfu_array #(.col(COL), .psum_bw(PBW), .cnt_bw(CBW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in       (in),
      .relu_en  (relu_en),
      .rd_req   (rd_req),
      .out_valid(out_valid),
      .out      (out),
      .acc_cnt  (acc_cnt),
      .sat_flag (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int             tests = 0;
   int             fails = 0;
   int             chIn      [COL];
   int             modelAcc  [COL];
   int             modelCnt;
   logic [COL-1:0] modelFlags;
   bit             modelPend;
   bit             expValid;
   logic [W-1:0]   expOutQ [$];
   logic [W-1:0]   lastOut;
   bit             monOn;

   task automatic compareVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput();
      compareVal("acc_cnt", W'(acc_cnt), W'(modelCnt));
      compareVal("sat_flag", W'(sat_flag), W'(modelFlags));
   endtask

   task automatic clearInputs();
      for (int c = 0; c < COL; c++) chIn[c] = 0;
   endtask

   // One clock of stimulus; the model is advanced with the values the DUT
   // sampled at that edge.
   task automatic applyStimulus(input bit iv, input bit rd, input bit relu);
      logic [W-1:0] vec;
      int s;
      vec = '0;
      for (int c = 0; c < COL; c++) vec[c*PBW +: PBW] = chIn[c][PBW-1:0];
      in_valid = iv;
      rd_req   = rd;
      relu_en  = relu;
      in       = vec;
      @(posedge clk);
      expValid = 1'b0;
      if (!rst) begin
         for (int c = 0; c < COL; c++) modelAcc[c] = 0;
         modelCnt   = 0;
         modelFlags = '0;
         modelPend  = 1'b0;
         lastOut    = '0;
         expOutQ.delete();
      end else if (iv) begin
         for (int c = 0; c < COL; c++) begin
            s = modelAcc[c] + chIn[c];
            if (s > VMAX) begin s = VMAX; modelFlags[c] = 1'b1; end
            if (s < VMIN) begin s = VMIN; modelFlags[c] = 1'b1; end
            modelAcc[c] = s;
         end
         if (modelCnt < (1 << CBW) - 1) modelCnt++;
         if (rd) modelPend = 1'b1;
      end else if (rd || modelPend) begin
         vec = '0;
         for (int c = 0; c < COL; c++) begin
            s = (relu && modelAcc[c] < 0) ? 0 : modelAcc[c];
            vec[c*PBW +: PBW] = s[PBW-1:0];
            modelAcc[c] = 0;
         end
         expOutQ.push_back(vec);
         lastOut    = vec;
         expValid   = 1'b1;
         modelCnt   = 0;
         modelFlags = '0;
         modelPend  = 1'b0;
      end
      #1;
      checkOutput();
   endtask

   // Monitor: every falling edge, out_valid must match the prediction; a
   // valid cycle consumes one scoreboard entry, an idle one must show the
   // held result.
   always @(negedge clk) begin
      if (monOn) begin
         compareVal("out_valid", W'(out_valid), W'(expValid));
         if (out_valid) begin
            if (expOutQ.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_readout: got %h expected none", out);
            end else begin
               compareVal("out_data", out, expOutQ.pop_front());
            end
         end else begin
            compareVal("out_hold", out, lastOut);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      monOn = 1'b0;
      rst = 1'b0;
      in_valid = 1'b0;
      rd_req = 1'b0;
      relu_en = 1'b0;
      in = '0;
      clearInputs();
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      monOn = 1'b1;
      compareVal("reset_out", out, '0);
      rst = 1'b1;

      // Basic accumulate and read.
      clearInputs();
      chIn[0] = 5;  chIn[7] = -4; applyStimulus(1, 0, 0);
      chIn[0] = -2;               applyStimulus(1, 0, 0);
      chIn[0] = 10;               applyStimulus(1, 0, 0);
      compareVal("basic_cnt3", W'(acc_cnt), W'(3));
      clearInputs();
      applyStimulus(0, 1, 0);
      compareVal("basic_ch0", W'(out[0 +: PBW]), W'(16'd13));
      compareVal("basic_ch7", W'(out[7*PBW +: PBW]), W'(16'hFFF4));
      applyStimulus(0, 0, 0);

      // ReLU readout followed immediately by a readout of the cleared unit.
      chIn[0] = 5;  chIn[7] = -4; applyStimulus(1, 0, 0);
      chIn[0] = -2;               applyStimulus(1, 0, 0);
      chIn[0] = 10;               applyStimulus(1, 0, 0);
      clearInputs();
      applyStimulus(0, 1, 1);
      compareVal("relu_ch7", W'(out[7*PBW +: PBW]), W'(0));
      applyStimulus(0, 1, 0);
      compareVal("relu_zero", out, '0);
      applyStimulus(0, 0, 0);

      // Saturation at both rails.
      chIn[1] = 32767; chIn[2] = -32768; applyStimulus(1, 0, 0);
      chIn[1] = 1;     chIn[2] = -1;     applyStimulus(1, 0, 0);
      compareVal("sat_flags", W'(sat_flag), W'(8'b0000_0110));
      clearInputs();
      applyStimulus(0, 1, 0);
      compareVal("sat_ch1", W'(out[1*PBW +: PBW]), W'(16'h7FFF));
      compareVal("sat_ch2", W'(out[2*PBW +: PBW]), W'(16'h8000));
      applyStimulus(0, 0, 0);

      // Request during accumulation is deferred and includes later data.
      chIn[0] = 6; applyStimulus(1, 0, 0);
      chIn[0] = 4; applyStimulus(1, 1, 0);
      chIn[0] = 1; applyStimulus(1, 0, 0);
      clearInputs();
      applyStimulus(0, 0, 0);
      compareVal("prio_ch0", W'(out[0 +: PBW]), W'(16'd11));
      applyStimulus(0, 0, 0);

      // Reset while a request is parked: nothing is read out afterwards.
      chIn[0] = 37; applyStimulus(1, 1, 0);
      rst = 1'b0;   applyStimulus(1, 1, 0);
      rst = 1'b1;
      clearInputs();
      compareVal("rst_out", out, '0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);

      // Counter saturation.
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
      compareVal("cnt_sat", W'(acc_cnt), W'(15));
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);

      // Randomised traffic, with occasional mid-stream resets.
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < COL; c++) begin
            if ($urandom_range(0, 3) == 0) chIn[c] = int'($urandom_range(0, 65535)) - 32768;
            else                           chIn[c] = int'($urandom_range(0, 200)) - 100;
         end
         rst = ($urandom_range(0, 49) != 0);
         applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
      rst = 1'b1;
      clearInputs();
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      compareVal("queue_drained", W'(expOutQ.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sfu_array.md
Name: sfu_array

Overview:
- Multi-channel special-function unit sitting below the PE-array output columns.
- Each of `col` channels accumulates partial sums with saturation. On request it emits a one-cycle result vector, with optional ReLU, and clears.
- Successor to the single-channel accumulator. Adds channel count, saturation, ReLU, deferred readout and an accumulation counter.

Parameters:
- col, 8, number of independent channels.
- psum_bw, 16, width of each channel's input, accumulator and output (two's complement).
- cnt_bw, 8, width of the accumulation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk; rst==0 resets.
- in_valid  input  1  accumulate `in` this cycle; has priority over a readout request.
- in  input  col*psum_bw  channel c occupies bits [c*psum_bw +: psum_bw], signed.
- relu_en  input  1  sampled on the cycle readout executes; 1 = clamp negatives to 0.
- rd_req  input  1  request readout of all channels.
- out_valid  output  1  one-cycle pulse; `out` holds fresh results.
- out  output  col*psum_bw  registered result vector, same packing as `in`.
- acc_cnt  output  cnt_bw  number of accumulations since last clear.
- sat_flag  output  col  per-channel sticky: saturation occurred since last clear.

Behaviour:
- Reset (rst==0 at posedge), regardless of state or pending request:
  - all accumulators = 0, out = 0, out_valid = 0, acc_cnt = 0, sat_flag = 0, rd_pend = 0.
- Accumulate (in_valid==1):
  - per channel, acc_c <= sat(acc_c + in_c).
  - Sum computed at psum_bw+1 bits; clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - Clamping sets sat_flag[c] = 1.
  - acc_cnt increments, saturating at 2^cnt_bw-1 (no wrap).
- Hold: in_valid==0 and no readout executing → all state holds.
- Readout request:
  - rd_req==1 sets internal rd_pend.
  - Readout executes in the first cycle where rd_pend (or rd_req) ==1 and in_valid==0.
- Readout cycle N, all in one edge:
  - out_c <= relu_en ? max(acc_c, 0) : acc_c.
  - out_valid <= 1.
  - acc_c <= 0, acc_cnt <= 0, sat_flag <= 0, rd_pend <= 0.
- Latency: rd_req at cycle N with in_valid==0 → out_valid=1 at cycle N+1, for exactly one cycle.
- out holds its value after out_valid drops, until the next readout or reset.
- rd_req and in_valid both 1 in the same cycle:
  - accumulation happens, rd_pend set.
  - readout occurs on the first later cycle with in_valid==0; the result includes that accumulation.
- rd_req held high across several cycles produces one readout per cycle in which it is asserted and in_valid==0.
- State machine (2 states):
  - IDLE: no pending request. rd_req & in_valid → PEND. rd_req & !in_valid → readout, stay IDLE.
  - PEND: rd_pend==1. !in_valid → readout, go IDLE. in_valid → stay PEND.
- Readout of a cleared unit (acc_cnt==0) is legal: emits zeros, out_valid pulses.
- relu_en does not affect the stored accumulators; it applies only on the output path.
- Channels are fully independent; saturation in one does not affect the others.
- Register out and out_valid only; no combinational path from inputs to outputs.

Test Plan:
- Reset: drive rst=0 mid-accumulation (acc_0=37, rd_pend=1) → next cycle out=0, out_valid=0, acc_cnt=0, no readout occurs after rst returns to 1.
- Basic accumulate and read (col=8, psum_bw=16):
  - stimulus: in_valid 3 cycles with ch0 = 5, -2, 10 and ch7 = -4 each; then rd_req, relu_en=0.
  - response: out ch0=13, ch7=-12, acc_cnt=3 before readout, out_valid one cycle after rd_req, acc_cnt=0 after.
- ReLU: same data with relu_en=1 → ch0=13, ch7=0; a second readout immediately after emits all zeros.
- Saturation:
  - ch1 accumulates 32767 then 1 → out ch1=32767, sat_flag[1]=1.
  - ch2 accumulates -32768 then -1 → -32768, sat_flag[2]=1.
  - other sat_flag bits stay 0; all flags clear after readout.
- Priority:
  - rd_req=1 with in_valid=1 at cycle N (in ch0=4, prior acc 6), in_valid=1 again at N+1 (in ch0=1), in_valid=0 at N+2.
  - response: out_valid at N+3 with ch0=11.
- Counter saturation (cnt_bw=4): 20 accumulations → acc_cnt stays 15; readout resets it to 0.
